// File: rtl/reqrsp_rr_mux.sv
// reqrsp_rr_mux: round-robin multiplexer of NrPorts reqrsp requesters onto one downstream port.
//
// Request (q) path: a round-robin arbiter picks one valid requester. Its payload is forwarded
// combinationally to mst_req_o. The grant is held while the downstream stalls (q_valid=1,
// q_ready=0). Each downstream q handshake records the granted port index in an in-order ID FIFO
// of depth MaxOutstanding. While that FIFO is full, no new request is issued.
//
// Response (p) path: responses are returned in order to the port at the FIFO head. The FIFO is
// popped on each downstream p handshake.
//
// Optional feature, enabled by defining REQRSP_RR_MUX_RSP_SPILL_EN:
//   A one-entry spill register (payload + port index) sits on the p path. This adds one cycle of
//   response latency and still sustains one response per cycle. Without the macro the p path is
//   purely combinational.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   slv_req_i  requests from the requesters   (q_valid, q, p_ready)
//   slv_rsp_o  responses to the requesters    (q_ready, p_valid, p)
//   mst_req_o  shared downstream request      (q_valid, q, p_ready)
//   mst_rsp_i  shared downstream response     (q_ready, p_valid, p)
//
// req_t / rsp_t default to reqrsp structs sized by AddrWidth/DataWidth. Users normally override
// them with their own reqrsp types.
module reqrsp_rr_mux #(
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter type req_t = struct packed {
    logic q_valid;
    struct packed {
      logic [AddrWidth-1:0]   addr;
      logic                   write;
      logic [DataWidth-1:0]   data;
      logic [DataWidth/8-1:0] strb;
    } q;
    logic p_ready;
  },
  parameter type rsp_t = struct packed {
    logic q_ready;
    logic p_valid;
    struct packed {
      logic [DataWidth-1:0] data;
      logic                 error;
    } p;
  }
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  req_t slv_req_i [NrPorts],
  output rsp_t slv_rsp_o [NrPorts],
  output req_t mst_req_o,
  input  rsp_t mst_rsp_i
);

  localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam idx_t LastPort = idx_t'(NrPorts - 1);
  localparam ptr_t LastPtr  = ptr_t'(MaxOutstanding - 1);
  localparam cnt_t FullCnt  = cnt_t'(MaxOutstanding);

  // Arbitration state.
  idx_t prio_q, prio_d;
  logic lock_q, lock_d;
  idx_t lock_idx_q, lock_idx_d;

  // In-order ID FIFO.
  idx_t fifo_q [MaxOutstanding];
  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  cnt_t count_q, count_d;

  idx_t arb_idx;
  logic arb_valid;
  idx_t gnt_idx;
  logic gnt_valid;
  logic q_valid_out;
  logic fifo_full;
  logic fifo_empty;
  idx_t head_idx;
  logic push;
  logic pop;
  logic rsp_accept;

  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);
  assign head_idx   = fifo_q[rptr_q];

  // Round-robin search: the first valid port at or after prio_q wins.
  always_comb begin
    int unsigned cand;
    idx_t        cand_idx;
    cand      = 0;
    cand_idx  = '0;
    arb_idx   = prio_q;
    arb_valid = 1'b0;
    for (int unsigned k = 0; k < NrPorts; k++) begin
      cand = k + 32'(prio_q);
      if (cand >= NrPorts) cand = cand - NrPorts;
      cand_idx = idx_t'(cand);
      if (!arb_valid && slv_req_i[cand_idx].q_valid) begin
        arb_valid = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // A stalled request keeps its grant so the downstream payload cannot change under it.
  assign gnt_idx   = lock_q ? lock_idx_q : arb_idx;
  assign gnt_valid = lock_q ? slv_req_i[lock_idx_q].q_valid : arb_valid;

  // Reset gates the issue path directly, because the requester valids are inputs.
  assign q_valid_out = rst_ni && gnt_valid && !fifo_full;
  assign push        = q_valid_out && mst_rsp_i.q_ready;

`ifdef REQRSP_RR_MUX_RSP_SPILL_EN
  logic                            spill_valid_q, spill_valid_d;
  idx_t                            spill_idx_q, spill_idx_d;
  logic [$bits(mst_rsp_i.p)-1:0]   spill_p_q, spill_p_d;
  logic                            spill_drain;

  // The spill counts as not full when it is empty or is draining this cycle.
  // This keeps the response path at one response per cycle.
  assign spill_drain = spill_valid_q && slv_req_i[spill_idx_q].p_ready;
  assign rsp_accept  = !fifo_empty && (!spill_valid_q || spill_drain);
  assign pop         = rsp_accept && mst_rsp_i.p_valid;

  always_comb begin
    spill_valid_d = spill_valid_q;
    spill_idx_d   = spill_idx_q;
    spill_p_d     = spill_p_q;
    if (pop) begin
      spill_valid_d = 1'b1;
      spill_idx_d   = head_idx;
      spill_p_d     = mst_rsp_i.p;
    end else if (spill_drain) begin
      spill_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spill_valid_q <= 1'b0;
      spill_idx_q   <= '0;
      spill_p_q     <= '0;
    end else begin
      spill_valid_q <= spill_valid_d;
      spill_idx_q   <= spill_idx_d;
      spill_p_q     <= spill_p_d;
    end
  end
`else
  assign rsp_accept = !fifo_empty && slv_req_i[head_idx].p_ready;
  assign pop        = rsp_accept && mst_rsp_i.p_valid;
`endif

  // Output steering.
  always_comb begin
    mst_req_o         = '0;
    mst_req_o.q_valid = q_valid_out;
    mst_req_o.q       = slv_req_i[gnt_idx].q;
    mst_req_o.p_ready = rsp_accept;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      slv_rsp_o[i]         = '0;
      slv_rsp_o[i].q_ready = q_valid_out && (gnt_idx == idx_t'(i)) && mst_rsp_i.q_ready;
`ifdef REQRSP_RR_MUX_RSP_SPILL_EN
      slv_rsp_o[i].p_valid = spill_valid_q && (spill_idx_q == idx_t'(i));
      slv_rsp_o[i].p       = spill_p_q;
`else
      slv_rsp_o[i].p_valid = !fifo_empty && (head_idx == idx_t'(i)) && mst_rsp_i.p_valid;
      slv_rsp_o[i].p       = mst_rsp_i.p;
`endif
    end
  end

  // Next state for the arbiter and the FIFO bookkeeping.
  always_comb begin
    prio_d     = prio_q;
    lock_d     = q_valid_out && !mst_rsp_i.q_ready;
    lock_idx_d = gnt_idx;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (push) begin
      prio_d = (gnt_idx == LastPort) ? '0 : gnt_idx + idx_t'(1);
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + ptr_t'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + ptr_t'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q <= '{default: '0};
    end else if (push) begin
      fifo_q[wptr_q] <= gnt_idx;
    end
  end

`ifndef SYNTHESIS
  // Requesters must hold q_valid until their handshake.
  for (genvar g = 0; g < NrPorts; g++) begin : gen_q_stable_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (slv_req_i[g].q_valid && !slv_rsp_o[g].q_ready) |=> slv_req_i[g].q_valid)
      else $error("reqrsp_rr_mux: port %0d dropped q_valid before handshake", g);
  end

  // A response with nothing outstanding is a downstream protocol error.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_rsp_i.p_valid |-> !fifo_empty)
    else $error("reqrsp_rr_mux: response received with no outstanding request");
`endif

endmodule
